// File: rtl/axi_read_arbiter_if.sv
// axi_read_arbiter_if
//   Bundles the AR/R handshake signals seen by the AXI read-channel
//   arbiter. Signal names match the original flat port list so that
//   surrounding interconnect code can bind to them unchanged.
//
//   Parameters: MasterCount, SlaveCount, AddrWidth (AddrWidth >= 32,
//   the slave region is taken from address bits [31:16]).
//
//   modport slave  : arbiter view (requests in, selects/readies out)
//   modport master : fabric/environment view (the mirror image)
interface axi_read_arbiter_if #(
    parameter int MasterCount = 2,
    parameter int SlaveCount  = 6,
    parameter int AddrWidth   = 32
);
    logic [MasterCount-1:0]           ARVALID_M;
    logic [MasterCount*AddrWidth-1:0] ARADDR_M;
    logic [MasterCount-1:0]           ARREADY_M;
    logic [SlaveCount-1:0]            ARVALID_S;
    logic [AddrWidth-1:0]             ARADDR_S;
    logic [SlaveCount-1:0]            ARREADY_S;
    logic [SlaveCount-1:0]            RVALID_S;
    logic [SlaveCount-1:0]            RLAST_S;
    logic [MasterCount-1:0]           RREADY_M;
    logic [MasterCount-1:0]           GRANT_M;
    logic [SlaveCount-1:0]            SEL_S;
    logic                             BUSY;

    modport slave (
        input  ARVALID_M, ARADDR_M, ARREADY_S, RVALID_S, RLAST_S, RREADY_M,
        output ARREADY_M, ARVALID_S, ARADDR_S, GRANT_M, SEL_S, BUSY
    );

    modport master (
        output ARVALID_M, ARADDR_M, ARREADY_S, RVALID_S, RLAST_S, RREADY_M,
        input  ARREADY_M, ARVALID_S, ARADDR_S, GRANT_M, SEL_S, BUSY
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
//   Read-channel controller for the AXI interconnect. Picks one of the
//   requesting masters on the AR channel, decodes its address into a
//   one-hot slave select and holds GRANT_M/SEL_S until the last R beat of
//   that burst has been accepted by the master.
//
//   Ports:
//     ACLK     - clock
//     ARESETn  - asynchronous active-low reset
//     bus      - axi_read_arbiter_if.slave: ARVALID_M/ARADDR_M/ARREADY_M
//                (master AR side), ARVALID_S/ARADDR_S/ARREADY_S (slave AR
//                side), RVALID_S/RLAST_S/RREADY_M (burst completion),
//                GRANT_M/SEL_S (registered mux selects), BUSY.
//
//   Address decode: slave i for addr[31:16] == i (i < SlaveCount-1),
//   anything else goes to the default slave SlaveCount-1.
//
//   Build option: define AXI_ARB_ROUND_ROBIN_EN for round-robin
//   arbitration starting at a rotating pointer; otherwise fixed priority
//   with the lowest master index winning.
module axi_read_arbiter #(
    parameter int MasterCount = 2,
    parameter int SlaveCount  = 6,
    parameter int AddrWidth   = 32
) (
    input logic               ACLK,
    input logic               ARESETn,
    axi_read_arbiter_if.slave bus
);

    localparam int IdxW = (MasterCount > 1) ? $clog2(MasterCount) : 1;
    localparam int SelW = (SlaveCount > 1) ? $clog2(SlaveCount) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t                state;
    logic [IdxW-1:0]       gidx;
    logic [AddrWidth-1:0]  addr_m [MasterCount];

    logic                  win_found;
    logic [IdxW-1:0]       win_idx;
    logic [15:0]           win_region;
    logic [SlaveCount-1:0] win_sel;
    logic [AddrWidth-1:0]  gnt_addr;
    logic                  ar_hs;
    logic                  r_done;

`ifdef AXI_ARB_ROUND_ROBIN_EN
    logic [IdxW-1:0]       ptr;
    logic [IdxW-1:0]       cand;
`endif

    // Unpack the flat address bus with constant slices.
    for (genvar m = 0; m < MasterCount; m++) begin : g_unpack
        assign addr_m[m] = bus.ARADDR_M[m*AddrWidth +: AddrWidth];
    end

    // Winner selection among the current requesters.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
        cand      = '0;
        for (int unsigned off = 0; off < MasterCount; off++) begin
            cand = IdxW'((32'(ptr) + off) % MasterCount);
            if (!win_found && bus.ARVALID_M[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`else
        for (int unsigned m = 0; m < MasterCount; m++) begin
            if (!win_found && bus.ARVALID_M[IdxW'(m)]) begin
                win_found = 1'b1;
                win_idx   = IdxW'(m);
            end
        end
`endif
    end

    // Region decode of the winner's address; default slave unless a
    // lower slave index matches exactly.
    always_comb begin
        win_region = addr_m[win_idx][31:16];
        win_sel    = '0;
        win_sel[SlaveCount-1] = 1'b1;
        for (int unsigned i = 0; i < SlaveCount - 1; i++) begin
            if (win_region == 16'(i)) begin
                win_sel = '0;
                win_sel[SelW'(i)] = 1'b1;
            end
        end
    end

    assign gnt_addr = addr_m[gidx];
    assign ar_hs    = bus.ARVALID_M[gidx] & (|(bus.ARREADY_S & bus.SEL_S));
    assign r_done   = (|(bus.RVALID_S & bus.RLAST_S & bus.SEL_S)) & bus.RREADY_M[gidx];

    // AR-side outputs stay combinational: ARREADY_M must follow ARREADY_S
    // in the same cycle, so only the select/grant state is registered.
    always_comb begin
        bus.ARVALID_S = '0;
        bus.ARREADY_M = '0;
        bus.ARADDR_S  = '0;
        if (state == ADDR) begin
            bus.ARVALID_S       = bus.SEL_S & {SlaveCount{bus.ARVALID_M[gidx]}};
            bus.ARREADY_M[gidx] = |(bus.ARREADY_S & bus.SEL_S);
            bus.ARADDR_S        = gnt_addr;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state       <= IDLE;
            gidx        <= '0;
            bus.GRANT_M <= '0;
            bus.SEL_S   <= '0;
            bus.BUSY    <= 1'b0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
            ptr         <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_found) begin
                        state       <= ADDR;
                        gidx        <= win_idx;
                        bus.GRANT_M <= MasterCount'(1) << win_idx;
                        bus.SEL_S   <= win_sel;
                        bus.BUSY    <= 1'b1;
                    end
                end
                ADDR: begin
                    // A granted master dropping ARVALID simply keeps us here.
                    if (ar_hs) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (r_done) begin
                        state       <= IDLE;
                        bus.GRANT_M <= '0;
                        bus.SEL_S   <= '0;
                        bus.BUSY    <= 1'b0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
                        ptr         <= (gidx == IdxW'(MasterCount - 1)) ? '0 : gidx + 1'b1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
